// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer: CSR read-modify-write, exceptions, external
// interrupt, mret, registered PC redirect and a post-redirect flush window. Macro CSR_COUNTERS_EN adds mcycle/minstret.
module csr_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_dout,
  output logic        csr_illegal,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic        retire_valid,
  input  logic [31:0] retire_npc,
  input  logic        irq_ext,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);
  localparam logic [1:0] OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

  localparam logic [11:0] A_MSTATUS  = 12'h300, A_MIE   = 12'h304, A_MTVEC = 12'h305,
                          A_MSCRATCH = 12'h340, A_MEPC  = 12'h341, A_MCAUSE = 12'h342,
                          A_MTVAL    = 12'h343, A_MIP   = 12'h344;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE  = 12'hB00, A_MCYCLEH  = 12'hB80,
                          A_MINSTR  = 12'hB02, A_MINSTRH  = 12'hB82,
                          A_CYCLE   = 12'hC00, A_CYCLEH   = 12'hC80,
                          A_INSTR   = 12'hC02, A_INSTRH   = 12'hC82;
`endif

  typedef enum logic {RUN, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`endif

  logic        impl, ro, do_write, irq_take, csr_we;
  logic [31:0] wval;

  // Combinational read port; also classifies the address
  always_comb begin
    impl     = 1'b1;
    ro       = 1'b0;
    csr_dout = '0;
    case (csr_addr)
      A_MSTATUS:  csr_dout = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      A_MIE:      csr_dout = {20'b0, meie_q, 11'b0};
      A_MIP:      csr_dout = {20'b0, irq_ext, 11'b0};
      A_MTVEC:    csr_dout = mtvec_q;
      A_MSCRATCH: csr_dout = mscratch_q;
      A_MEPC:     csr_dout = mepc_q;
      A_MCAUSE:   csr_dout = mcause_q;
      A_MTVAL:    csr_dout = mtval_q;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:   csr_dout = mcycle_q[31:0];
      A_MCYCLEH:  csr_dout = mcycle_q[63:32];
      A_MINSTR:   csr_dout = minstret_q[31:0];
      A_MINSTRH:  csr_dout = minstret_q[63:32];
      A_CYCLE:    begin csr_dout = mcycle_q[31:0];    ro = 1'b1; end
      A_CYCLEH:   begin csr_dout = mcycle_q[63:32];   ro = 1'b1; end
      A_INSTR:    begin csr_dout = minstret_q[31:0];  ro = 1'b1; end
      A_INSTRH:   begin csr_dout = minstret_q[63:32]; ro = 1'b1; end
`endif
      default:    impl = 1'b0;
    endcase
  end

  // RS/RC with a zero mask is a pure read
  assign do_write    = (csr_op == OP_RW) || (csr_op != OP_NONE && csr_wdata != '0);
  assign csr_illegal = (csr_op != OP_NONE) && (!impl || (ro && do_write));

  always_comb begin
    wval = csr_wdata;
    case (csr_op)
      OP_RS:   wval = csr_dout | csr_wdata;
      OP_RC:   wval = csr_dout & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
  end

  assign irq_take = mie_q & meie_q & irq_ext & retire_valid & ~exc_valid;
  assign csr_we   = (state_q == RUN) & do_write & ~csr_illegal & ~exc_valid & ~irq_take & ~mret;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    rv_d       = 1'b0;
    rpc_d      = rpc_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, retire_valid};
`endif
    case (state_q)
      RUN: begin
        if (exc_valid || irq_take) begin
          mepc_d   = exc_valid ? {exc_pc[31:2], 2'b00} : {retire_npc[31:2], 2'b00};
          mcause_d = exc_valid ? {28'b0, exc_cause} : 32'h8000_000B;
          mtval_d  = exc_valid ? exc_tval : 32'h0;
          mpie_d   = mie_q;
          mie_d    = 1'b0;
          rv_d     = 1'b1;
          rpc_d    = mtvec_q;
        end else if (mret) begin
          mie_d  = mpie_q;
          mpie_d = 1'b1;
          rv_d   = 1'b1;
          rpc_d  = mepc_q;
        end else if (csr_we) begin
          case (csr_addr)
            A_MSTATUS:  begin mie_d = wval[3]; mpie_d = wval[7]; end
            A_MIE:      meie_d     = wval[11];
            A_MTVEC:    mtvec_d    = {wval[31:2], 2'b00};
            A_MSCRATCH: mscratch_d = wval;
            A_MEPC:     mepc_d     = {wval[31:2], 2'b00};
            A_MCAUSE:   mcause_d   = wval;
            A_MTVAL:    mtval_d    = wval;
`ifdef CSR_COUNTERS_EN
            // A written half takes the software value; the other half holds
            A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wval};
            A_MCYCLEH:  mcycle_d   = {wval, mcycle_q[31:0]};
            A_MINSTR:   minstret_d = {minstret_q[63:32], wval};
            A_MINSTRH:  minstret_d = {wval, minstret_q[31:0]};
`endif
            default: ;
          endcase
        end
        if (rv_d) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      rv_q       <= 1'b0;
      rpc_q      <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= '0;
      minstret_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      rv_q       <= rv_d;
      rpc_q      <= rpc_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign busy           = (state_q == FLUSH);
endmodule
